// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with held grants
//
// Purpose: shares one downstream resource among eight requesters. A rotating
// priority pointer feeds an 8-to-3 priority encoder; the winner's grant is
// registered and held until done, until the owner drops its request, or
// (with RR_ARB_TIMEOUT_EN defined) until the hold counter expires.
//
// Optional feature macro: RR_ARB_TIMEOUT_EN (hold counter + forced release).
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req[7:0]   in   request vector, held by each requester until served
//   done       in   one-cycle completion pulse from the current owner
//   gnt[7:0]   out  registered one-hot grant, zero when idle
//   gnt_idx    out  binary index of the owner, zero when idle
//   gnt_valid  out  |gnt
//   timeout    out  one-cycle pulse following a forced release

module rr_arbiter8 #(
  parameter int NREQ    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  if (NREQ != 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("rr_arbiter8: NREQ must be 8 and TIMEOUT must be in 2..255");
  end

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;

  logic       any_req;
  logic       expire;
  logic       release_w;
  logic       forced;
  logic [2:0] arb_ptr;
  logic [15:0] rot_wide;
  logic [7:0] rot_req;
  logic [2:0] win_idx;

  // Team 8-to-3 priority encoder: lowest set bit wins.
  function automatic logic [2:0] prio_enc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign expire = (cnt_q == 8'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  assign any_req   = |req;
  assign release_w = (state_q == S_BUSY) && (done || !req[idx_q] || expire);
  // Expiry only counts as forced when it is the sole reason for release.
  assign forced    = (state_q == S_BUSY) && expire && !done && req[idx_q];

  // On release the pointer moves past the owner in the same edge, so the
  // new arbitration already sees the just-released requester as lowest.
  assign arb_ptr  = release_w ? (idx_q + 3'd1) : ptr_q;
  assign rot_wide = {req, req} >> arb_ptr;
  assign rot_req  = rot_wide[7:0];
  assign win_idx  = prio_enc8(rot_req) + arb_ptr;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_BUSY;
          gnt_d   = 8'b1 << win_idx;
          idx_d   = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_BUSY: begin
        if (release_w) begin
          ptr_d     = arb_ptr;
          timeout_d = forced;
          if (any_req) begin
            gnt_d = 8'b1 << win_idx;
            idx_d = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
          end else begin
            state_d = S_IDLE;
            gnt_d   = 8'd0;
            idx_d   = 3'd0;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 8'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      gnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      timeout_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8

module tb_rr_arbiter8;

  localparam int TMO = 16;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks;
  int n_pass;

  // Reference model: owner number (-1 = none), priority start, cycles held.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_arbiter8 #(.NREQ(8), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // First requester found scanning ptr, ptr+1, ... modulo 8.
  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] rq, input logic d);
    bit exp_hit;
    bit rel;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner < 0) begin
      if (rq != 8'd0) begin
        m_owner = pick(rq, m_ptr);
        m_hold  = 0;
      end
    end else begin
      exp_hit = TO_EN && (m_hold == TMO - 1);
      rel     = d || !rq[m_owner] || exp_hit;
      if (rel) begin
        m_to  = exp_hit && !d && rq[m_owner];
        m_ptr = (m_owner + 1) % 8;
        if (rq != 8'd0) begin
          m_owner = pick(rq, m_ptr);
          m_hold  = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d);
    logic [7:0] e_gnt;
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    model_edge(r, rq, d);
    @(negedge clk);
    e_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    check("gnt", {24'd0, gnt}, {24'd0, e_gnt});
    check("gnt_idx", {29'd0, gnt_idx}, (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("gnt_valid", {31'd0, gnt_valid}, {31'd0, (m_owner >= 0)});
    check("timeout", {31'd0, timeout}, {31'd0, m_to});
  endtask

  logic [7:0] rnd_req;

  initial begin
    n_checks = 0; n_pass = 0;
    m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0;
    rst = 1'b1; req = 8'd0; done = 1'b0;
    @(negedge clk);

    // Reset with every request asserted.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    check("rst_gnt", {24'd0, gnt}, 32'd0);

    // Single request, then release.
    step(1'b0, 8'b0001_0000, 1'b0);
    check("single_idx", {29'd0, gnt_idx}, 32'd4);
    step(1'b0, 8'h00, 1'b1);
    check("single_rel", {24'd0, gnt}, 32'd0);

    // Rotation through all eight with back-to-back grants.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    check("rot_0", {29'd0, gnt_idx}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      check("rot_seq", {29'd0, gnt_idx}, 32'(i % 8));
      check("rot_valid", {31'd0, gnt_valid}, 32'd1);
    end

    // Wrap and fairness: owner 5 releases, 0 next, then 5.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'b0010_0000, 1'b0);
    check("wrap_own5", {29'd0, gnt_idx}, 32'd5);
    step(1'b0, 8'b0010_0001, 1'b1);
    check("wrap_to0", {29'd0, gnt_idx}, 32'd0);
    step(1'b0, 8'b0010_0001, 1'b1);
    check("wrap_to5", {29'd0, gnt_idx}, 32'd5);

    // Timeout: req[2] held, done never pulsed.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h04, 1'b0);
    for (int i = 1; i < TMO; i++) begin
      step(1'b0, 8'h04, 1'b0);
      check("tmo_hold", {31'd0, timeout}, 32'd0);
    end
    step(1'b0, 8'h04, 1'b0);
    check("tmo_pulse", {31'd0, timeout}, TO_EN ? 32'd1 : 32'd0);
    check("tmo_regrant", {29'd0, gnt_idx}, 32'd2);
    check("tmo_nogap", {31'd0, gnt_valid}, 32'd1);
    step(1'b0, 8'h04, 1'b0);
    check("tmo_once", {31'd0, timeout}, 32'd0);

    // Mid-grant reset, then pointer restarts at 0.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h40, 1'b0);
    check("mid_own6", {29'd0, gnt_idx}, 32'd6);
    step(1'b1, 8'h40, 1'b0);
    check("mid_rst_gnt", {24'd0, gnt}, 32'd0);
    check("mid_rst_idx", {29'd0, gnt_idx}, 32'd0);
    step(1'b0, 8'hC0, 1'b0);
    check("mid_first6", {29'd0, gnt_idx}, 32'd6);

    // Randomized traffic with sticky requests against the model.
    rnd_req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      rnd_req = rnd_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) rnd_req = rnd_req | 8'($urandom);
      step(($urandom_range(0, 299) == 0), rnd_req, ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
